// File: rtl/d_input_debouncer.sv
// d_input_debouncer: 2-flop synchroniser + stability-count FSM giving a clean level and edge pulse.
// Define DEBOUNCE_FALL_PULSE_EN to add the one-cycle fall output.
module d_input_debouncer #(
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic q,
   output logic rise
`ifdef DEBOUNCE_FALL_PULSE_EN
   ,
   output logic fall
`endif
);

   typedef enum logic [1:0] {
      LOW,
      WAIT_HIGH,
      HIGH,
      WAIT_LOW
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam bit               FAST = (STABLE_CYCLES == 1);

   logic             sync1;
   logic             sync2;
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             q_n;
   logic             rise_n;
`ifdef DEBOUNCE_FALL_PULSE_EN
   logic             fall_n;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= LOW;
         cnt   <= '0;
         q     <= 1'b0;
         rise  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
         fall  <= 1'b0;
`endif
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         state <= state_n;
         cnt   <= cnt_n;
         q     <= q_n;
         rise  <= rise_n;
`ifdef DEBOUNCE_FALL_PULSE_EN
         fall  <= fall_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         LOW: begin
            if (sync2) begin
               if (FAST) begin
                  state_n = HIGH;
               end else begin
                  state_n = WAIT_HIGH;
                  cnt_n   = ONE;
               end
            end
         end
         WAIT_HIGH: begin
            if (!sync2) begin
               state_n = LOW;
               cnt_n   = '0;
            end else if (cnt == LAST) begin
               state_n = HIGH;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
         HIGH: begin
            if (!sync2) begin
               if (FAST) begin
                  state_n = LOW;
               end else begin
                  state_n = WAIT_LOW;
                  cnt_n   = ONE;
               end
            end
         end
         WAIT_LOW: begin
            if (sync2) begin
               state_n = HIGH;
               cnt_n   = '0;
            end else if (cnt == LAST) begin
               state_n = LOW;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
      endcase
   end

   // outputs are registered from the next state so q moves on the deciding edge
   always_comb begin
      q_n    = (state_n == HIGH) || (state_n == WAIT_LOW);
      rise_n = q_n & ~q;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall_n = ~q_n & q;
`endif
   end

endmodule

// File: tb/tb_d_input_debouncer.sv
// tb_d_input_debouncer: random + directed stimulus on two instances (4-cycle and 1-cycle filters)
// compared each cycle against a run-length reference model.
module tb_d_input_debouncer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic din = 1'b0;
   logic q4, r4, q1, r1;
`ifdef DEBOUNCE_FALL_PULSE_EN
   logic f4, f1;
`endif

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   d_input_debouncer #(.STABLE_CYCLES(4), .CNT_W(5)) u4 (
      .clk(clk), .reset(reset), .din(din), .q(q4), .rise(r4)
`ifdef DEBOUNCE_FALL_PULSE_EN
      , .fall(f4)
`endif
   );

   d_input_debouncer #(.STABLE_CYCLES(1), .CNT_W(5)) u1 (
      .clk(clk), .reset(reset), .din(din), .q(q1), .rise(r1)
`ifdef DEBOUNCE_FALL_PULSE_EN
      , .fall(f1)
`endif
   );

   // reference: q flips once S consecutive synchronised samples differ from it
   int   sv[2] = '{4, 1};
   logic m_s1, m_s2, samp;
   logic m_q[2], m_r[2], m_f[2];
   int   m_run[2];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_q[i] = 1'b0; m_r[i] = 1'b0; m_f[i] = 1'b0; m_run[i] = 0;
         end
      end else begin
         samp = m_s2;
         m_s2 = m_s1;
         m_s1 = din;
         for (int i = 0; i < 2; i++) begin
            m_r[i] = 1'b0;
            m_f[i] = 1'b0;
            if (samp == m_q[i]) begin
               m_run[i] = 0;
            end else begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] >= sv[i]) begin
                  m_q[i]   = samp;
                  m_run[i] = 0;
                  m_r[i]   = samp;
                  m_f[i]   = ~samp;
               end
            end
         end
      end
   end

   task automatic check(input string nm, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_q4", q4, m_q[0]);
      check("model_rise4", r4, m_r[0]);
      check("model_q1", q1, m_q[1]);
      check("model_rise1", r1, m_r[1]);
`ifdef DEBOUNCE_FALL_PULSE_EN
      check("model_fall4", f4, m_f[0]);
      check("model_fall1", f1, m_f[1]);
      check("rise_fall_excl4", r4 & f4, 1'b0);
      check("rise_fall_excl1", r1 & f1, 1'b0);
`endif
   end

   initial begin
      int len;
      int mode;
      reset = 1'b0;
      din   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_q", q4, 1'b0);
      check("rst_rise", r4, 1'b0);
      check("rst_sync1", u4.sync1, 1'b0);
      check("rst_sync2", u4.sync2, 1'b0);
      check("rst_cnt", u4.cnt == '0, 1'b1);
      reset = 1'b1;
      @(negedge clk);

      // clean press
      din = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         if (e == 2) check("s1_q_e2", q1, 1'b0);
         if (e == 3) begin
            check("s1_q_e3", q1, 1'b1);
            check("s1_rise_e3", r1, 1'b1);
         end
         if (e == 4) check("s1_rise_e4", r1, 1'b0);
         if (e == 5) check("press_q_e5", q4, 1'b0);
         if (e == 6) begin
            check("press_q_e6", q4, 1'b1);
            check("press_rise_e6", r4, 1'b1);
         end
         if (e > 6) check("press_rise_after", r4, 1'b0);
      end

      // release
      din = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         if (e == 5) check("rel_q_e5", q4, 1'b1);
         if (e == 6) check("rel_q_e6", q4, 1'b0);
         check("rel_rise", r4, 1'b0);
`ifdef DEBOUNCE_FALL_PULSE_EN
         check("rel_fall", f4, e == 6);
`endif
      end

      // bounce reject
      din = 1'b1;
      repeat (2) @(negedge clk);
      din = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("bounce_q", q4, 1'b0);
      end
      for (int b = 0; b < 8; b++) begin
         din = 1'b1;
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            check("burst_q", q4, 1'b0);
            check("burst_rise", r4, 1'b0);
         end
         din = 1'b0;
         repeat ($urandom_range(2, 5)) begin
            @(negedge clk);
            check("burst_q", q4, 1'b0);
         end
      end
      repeat (6) @(negedge clk);

      // toggling every cycle never moves the 4-cycle filter
      for (int t = 0; t < 20; t++) begin
         din = ~din;
         @(negedge clk);
         check("toggle_q", q4, 1'b0);
      end
      din = 1'b0;
      repeat (6) @(negedge clk);

      // reset mid-count
      din = 1'b1;
      repeat (4) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("mid_rst_q", q4, 1'b0);
      check("mid_rst_rise", r4, 1'b0);
      check("mid_rst_sync1", u4.sync1, 1'b0);
      check("mid_rst_sync2", u4.sync2, 1'b0);
      check("mid_rst_cnt", u4.cnt == '0, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         if (e == 5) check("post_rst_q_e5", q4, 1'b0);
         if (e == 6) begin
            check("post_rst_q_e6", q4, 1'b1);
            check("post_rst_rise_e6", r4, 1'b1);
         end
      end

      // randomized segments
      for (int s = 0; s < 300; s++) begin
         mode = $urandom_range(0, 3);
         len  = $urandom_range(1, 24);
         for (int c = 0; c < len; c++) begin
            unique case (mode)
               0: din = 1'($urandom_range(0, 1));
               1: din = ~din;
               2: din = din;
               default: din = (c < 3) ? ~din : din;
            endcase
            @(negedge clk);
         end
         if ($urandom_range(0, 39) == 0) begin
            @(posedge clk);
            #2 reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
      end

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
